// File: rtl/a_input_conditioner_if.sv
// Signal bundle between the raw-level source and a_input_conditioner.
// The glitch_cnt member exists only when A_GLITCH_COUNT_EN is defined.
interface a_input_conditioner_if
`ifdef A_GLITCH_COUNT_EN
  #(parameter int GLITCH_W = 8)
`endif
  ;
  logic raw_in;
  logic enable;
  logic a;
  logic rise;
  logic fall;
`ifdef A_GLITCH_COUNT_EN
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (output raw_in, enable, input a, rise, fall, glitch_cnt);
  modport slave  (input raw_in, enable, output a, rise, fall, glitch_cnt);
`else
  modport master (output raw_in, enable, input a, rise, fall);
  modport slave  (input raw_in, enable, output a, rise, fall);
`endif
endinterface

// File: rtl/a_input_conditioner.sv
// Synchronises and debounces raw_in into the clean level a, with rise/fall pulses.
// Define A_GLITCH_COUNT_EN to add the saturating glitch_cnt output.
module a_input_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  a_input_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4)
    $error("SYNC_STAGES must be in 2..4");
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255)
    $error("STABLE_CYCLES must be in 1..255");
  if (GLITCH_W < 1)
    $error("GLITCH_W must be at least 1");

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   a_q, a_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.raw_in};
  assign s      = sync_q[SYNC_STAGES-1];

  // NOTE: every reg, including the synchroniser chain, is cleared by the async reset.
  // NOTE: sequential state uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= LOW;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.enable) begin
      // Dropping enable abandons any pending change without touching a.
      cnt_d = '0;
      if (state_q == RISE_PEND) state_d = LOW;
      if (state_q == FALL_PEND) state_d = HIGH;
    end else begin
      case (state_q)
        LOW: begin
          if (s) begin
            if (STABLE_CYCLES == 1) begin
              state_d = HIGH;
            end else begin
              state_d = RISE_PEND;
              cnt_d   = 8'd1;
            end
          end
        end
        RISE_PEND: begin
          if (!s) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (cnt_q == LAST_CNT) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        HIGH: begin
          if (!s) begin
            if (STABLE_CYCLES == 1) begin
              state_d = LOW;
            end else begin
              state_d = FALL_PEND;
              cnt_d   = 8'd1;
            end
          end
        end
        FALL_PEND: begin
          if (s) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == LAST_CNT) begin
            state_d = LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    a_d    = (state_d == HIGH) || (state_d == FALL_PEND);
    rise_d = (state_d == HIGH) && ((state_q == LOW) || (state_q == RISE_PEND));
    fall_d = (state_d == LOW) && ((state_q == HIGH) || (state_q == FALL_PEND));
  end

  assign bus.a    = a_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

`ifdef A_GLITCH_COUNT_EN
  logic                glitch_ev;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  assign glitch_ev = bus.enable &&
                     (((state_q == RISE_PEND) && !s) || ((state_q == FALL_PEND) && s));

  always_comb begin
    glitch_d = glitch_q;
    if (glitch_ev && (glitch_q != '1)) glitch_d = glitch_q + GLITCH_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) glitch_q <= '0;
    else       glitch_q <= glitch_d;
  end

  assign bus.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_a_input_conditioner.sv
// Directed bench for a_input_conditioner at default timing (2 sync stages, 4 stable cycles).
// With A_GLITCH_COUNT_EN the glitch counter is 2 bits wide to exercise saturation.
module tb_a_input_conditioner;

  logic clk;
  logic reset;
  int   total;
  int   bad;

`ifdef A_GLITCH_COUNT_EN
  a_input_conditioner_if #(.GLITCH_W(2)) bus ();
`else
  a_input_conditioner_if bus ();
`endif

  a_input_conditioner #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .GLITCH_W     (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic raw;
    logic en;
    logic a;
    logic rise;
    logic fall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input int n, input logic raw, input logic en,
                         input logic a, input logic r, input logic f);
    vec_t v;
    v.raw = raw; v.en = en; v.a = a; v.rise = r; v.fall = f;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check_outs(input string name, input logic a, input logic r, input logic f);
    check({name, ".a"},    int'(bus.a),    int'(a));
    check({name, ".rise"}, int'(bus.rise), int'(r));
    check({name, ".fall"}, int'(bus.fall), int'(f));
  endtask

  task automatic check_glitch(input string name, input int exp);
`ifdef A_GLITCH_COUNT_EN
    check(name, int'(bus.glitch_cnt), exp);
`else
    if (exp < 0) $display("unexpected glitch expectation %0d", exp);
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.raw_in = 1'b1;
    bus.enable = 1'b1;

    // Reset held with input high: outputs stay clear.
    for (int k = 1; k <= 3; k++) begin
      step();
      check_outs($sformatf("reset_hold%0d", k), 1'b0, 1'b0, 1'b0);
    end
    check_glitch("reset_hold.glitch", 0);

    // Release with input still high: a rises after the 6th edge.
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check_outs($sformatf("release_e%0d", k), logic'(k >= 6), logic'(k == 6), 1'b0);
    end

    // Return to a clean LOW state with empty synchroniser.
    reset = 1'b1;
    bus.raw_in = 1'b0;
    step();
    reset = 1'b0;

    // Clean rise, 10 cycles high, clean fall.
    add_vec(5, 1, 1, 0, 0, 0);
    add_vec(1, 1, 1, 1, 1, 0);
    add_vec(4, 1, 1, 1, 0, 0);
    add_vec(5, 0, 1, 1, 0, 0);
    add_vec(1, 0, 1, 0, 0, 1);
    add_vec(2, 0, 1, 0, 0, 0);
    // Two-cycle pulse is rejected.
    add_vec(2, 1, 1, 0, 0, 0);
    add_vec(6, 0, 1, 0, 0, 0);
    // Enable dropped during RISE_PEND, then requalified.
    add_vec(3, 1, 1, 0, 0, 0);
    add_vec(2, 1, 0, 0, 0, 0);
    add_vec(3, 1, 1, 0, 0, 0);
    add_vec(1, 1, 1, 1, 1, 0);
    add_vec(1, 1, 1, 1, 0, 0);
    // Enable dropped during FALL_PEND, then requalified.
    add_vec(3, 0, 1, 1, 0, 0);
    add_vec(2, 0, 0, 1, 0, 0);
    add_vec(3, 0, 1, 1, 0, 0);
    add_vec(1, 0, 1, 0, 0, 1);
    add_vec(1, 0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      bus.raw_in = vecs[i].raw;
      bus.enable = vecs[i].en;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].a, vecs[i].rise, vecs[i].fall);
    end
    check_glitch("table.glitch", 1);

    // Reset asserted mid FALL_PEND clears outputs without a clock edge.
    bus.raw_in = 1'b1;
    bus.enable = 1'b1;
    repeat (7) step();
    check("pre_fall.a", int'(bus.a), 1);
    bus.raw_in = 1'b0;
    repeat (3) step();
    check("fall_pend.a", int'(bus.a), 1);
    #3;
    reset = 1'b1;
    #1;
    check_outs("async_reset", 1'b0, 1'b0, 1'b0);
    check_glitch("async_reset.glitch", 0);
    step();
    reset = 1'b0;

    // Three-sample pulses (one short of qualifying) are rejected; counter saturates.
    for (int g = 0; g < 5; g++) begin
      bus.raw_in = 1'b1;
      for (int k = 0; k < 9; k++) begin
        if (k == 3) bus.raw_in = 1'b0;
        step();
        check_outs($sformatf("glitch%0d_c%0d", g, k), 1'b0, 1'b0, 1'b0);
      end
      check_glitch($sformatf("sat%0d", g), (g + 1 > 3) ? 3 : g + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a_input_conditioner.md
# a_input_conditioner

Upstream stage for the three-state sequence `fsm` (IDLE / STATE_1 / FINAL). It takes a raw, asynchronous, possibly bouncing level and synchronises it to `clk`. It then debounces the level and drives the clean `a` level that the `fsm` samples. It also produces single-cycle rise and fall pulses for logging and interrupt logic.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops; legal range is 2 to 4.
- `STABLE_CYCLES`, default 4: number of consecutive identical synchronised samples needed to change `a`; legal range is 1 to 255.
- `GLITCH_W`, default 8: width of the glitch counter. Only used when `A_GLITCH_COUNT_EN` is defined.
- `clk`, in, 1: sole clock. Rising edge only.
- `reset`, in, 1: asynchronous, active-high reset.
- `raw_in`, in, 1: raw asynchronous input level.
- `enable`, in, 1: qualification enable.
- `a`, out, 1: debounced level. Feeds `fsm.a` directly.
- `rise`, out, 1: one-cycle pulse when `a` goes 0→1.
- `fall`, out, 1: one-cycle pulse when `a` goes 1→0.
- `glitch_cnt`, out, `GLITCH_W`: saturating count of rejected transitions. Present only with `A_GLITCH_COUNT_EN`.

## Operation
- **Synchroniser.** `SYNC_STAGES` flops in series on `raw_in`. The last flop is `s`. The chain runs regardless of `enable`.
- **FSM states:**
  - LOW: `a` = 0.
  - RISE_PEND: `a` = 0, `s` = 1 being qualified.
  - HIGH: `a` = 1.
  - FALL_PEND: `a` = 1, `s` = 0 being qualified.
- **Counter.** 8-bit `cnt` counts accepted samples while in a PEND state. It is zeroed on every entry to LOW or HIGH.
- **Transitions** (evaluated at each edge with `enable` = 1):
  - LOW, `s` = 1, `STABLE_CYCLES` = 1: go to HIGH.
  - LOW, `s` = 1, `STABLE_CYCLES` > 1: go to RISE_PEND with `cnt` = 1.
  - RISE_PEND, `s` = 1, `cnt` = `STABLE_CYCLES`−1: go to HIGH.
  - RISE_PEND, `s` = 1, otherwise: `cnt` increments.
  - RISE_PEND, `s` = 0: return to LOW. This is a glitch.
  - HIGH and FALL_PEND: mirror of the above with `s` inverted.
- **`enable` = 0.**
  - RISE_PEND returns to LOW and FALL_PEND returns to HIGH.
  - `cnt` is cleared.
  - No glitch is counted.
  - `a` holds its value. No pulses are produced.
- **Outputs.**
  - `a`, `rise` and `fall` are registered.
  - `rise` is 1 for exactly the cycle following the edge that enters HIGH from LOW or RISE_PEND.
  - `fall` behaves the same for entry into LOW from HIGH or FALL_PEND.
  - `rise` and `fall` are never both 1.
- **Glitch counter.** Increments by 1 on each PEND→stable return caused by `s` reverting. It saturates at all-ones and does not wrap.
- **Reset.** All synchroniser flops, the state, `cnt`, `glitch_cnt`, `a`, `rise` and `fall` go to 0 immediately; the state goes to LOW. Reset applies in any state, including mid-PEND; that pending transition is discarded and not counted as a glitch.

## Timing
- Let edge 1 be the first rising edge that captures a new `raw_in` level, with setup met.
  - `s` reflects that level after edge `SYNC_STAGES`.
  - `a` changes after edge `SYNC_STAGES`+`STABLE_CYCLES`; with defaults, after edge 6.
  - The matching `rise` or `fall` is high during the same cycle as the `a` change.
- The `fsm` samples `a` one edge later, so the end-to-end latency from `raw_in` to the `fsm` state is `SYNC_STAGES`+`STABLE_CYCLES`+1 edges.
- A raw pulse is rejected if it yields fewer than `STABLE_CYCLES` consecutive samples of `s`.
- Output values after reset: `a` = 0, `rise` = 0, `fall` = 0, `glitch_cnt` = 0.
- Reset deassertion is asynchronous. The FSM evaluates normally from the first edge after release.

## Configuration
- `A_GLITCH_COUNT_EN`
  - Defined: the `glitch_cnt` port and its counter exist as described above.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- **Reset with input high.** Hold `reset` = 1 with `raw_in` = 1 for 3 edges, giving `a` = 0 and `rise` = 0. Release `reset` with `raw_in` held at 1: `a` = 1 and `rise` = 1 after edge 6 post-release, and `rise` = 0 after edge 7.
- **Clean rise and fall** (defaults, `enable` = 1).
  - Set `raw_in` 0→1 before edge 1: `a` = 1 after edge 6.
  - Set `raw_in` 1→0 ten cycles later: `a` = 0 and `fall` = 1 after 6 more edges.
  - The downstream `fsm` walks IDLE→STATE_1→FINAL, then returns to IDLE.
- **Glitch rejection.** `raw_in` high for 2 cycles then low: `a` stays 0, `rise` never pulses, and `glitch_cnt` goes 0→1.
- **Enable drop.** `raw_in` rises and `enable` is pulled to 0 during RISE_PEND: `a` stays 0 and `glitch_cnt` is unchanged. After `enable` returns to 1 with `raw_in` still high, `a` = 1 after `STABLE_CYCLES` edges.
- **Reset mid-operation.** Assert `reset` in FALL_PEND: `a` = 0, `fall` = 0 and `glitch_cnt` = 0 immediately, with no edge required.
- **Saturation.** With `GLITCH_W` = 2, apply 5 rejected glitches: `glitch_cnt` sequence is 1, 2, 3, 3, 3.
